// File: rtl/gbc_timer_pkg.sv
// Shared definitions for the GBC DIV/TIMA/TMA/TAC timer: register map, tap bits, reload states.
package gbc_timer_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    localparam logic [3:0] TAP_BIT_00 = 4'd9;
    localparam logic [3:0] TAP_BIT_01 = 4'd3;
    localparam logic [3:0] TAP_BIT_10 = 4'd5;
    localparam logic [3:0] TAP_BIT_11 = 4'd7;

    localparam logic [4:0] TAC_PAD_BITS = 5'b11111;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StOvfWait = 2'd1,
        StReload  = 2'd2
    } reload_state_e;

    function automatic logic [3:0] tap_bit(input logic [1:0] sel);
        logic [3:0] bit_idx;
        unique case (sel)
            2'b00:   bit_idx = TAP_BIT_00;
            2'b01:   bit_idx = TAP_BIT_01;
            2'b10:   bit_idx = TAP_BIT_10;
            default: bit_idx = TAP_BIT_11;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/gbc_timer_if.sv
// CPU IO-register control signals seen by the timer; the data bus stays a plain inout port.
interface gbc_timer_if;

    logic [15:0] I_IOREG_ADDR;
    logic        I_IOREG_WE_L;
    logic        I_IOREG_RE_L;

    modport master (
        output I_IOREG_ADDR,
        output I_IOREG_WE_L,
        output I_IOREG_RE_L
    );

    modport slave (
        input I_IOREG_ADDR,
        input I_IOREG_WE_L,
        input I_IOREG_RE_L
    );

endinterface

// File: rtl/gbc_timer_reload_fsm.sv
// TIMA overflow sequencer: delay counter, CPU-write cancel, TMA reload strobe / interrupt pulse.
module gbc_timer_reload_fsm
    import gbc_timer_pkg::*;
#(
    parameter int unsigned P_RELOAD_DELAY = 4
) (
    input  logic clk_i,
    input  logic sync_reset_i,
    input  logic freeze_i,
    input  logic ovf_i,
    input  logic tima_wr_i,
    output logic reload_o
);

    localparam logic [3:0] DelayLoad = 4'(P_RELOAD_DELAY - 32'd1);

    reload_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (sync_reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ovf_i) begin
                    if (P_RELOAD_DELAY == 1) begin
                        state_d = StReload;
                    end else begin
                        state_d = StOvfWait;
                        cnt_d   = DelayLoad;
                    end
                end
            end
            StOvfWait: begin
                // A CPU write to TIMA during the wait swallows the pending reload and interrupt.
                if (tima_wr_i) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (!freeze_i) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StReload;
                    end
                end
            end
            StReload: begin
                if (!freeze_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        reload_o = (state_q == StReload) && !freeze_i;
    end

endmodule

// File: rtl/gbc_timer.sv
// GBC DIV/TIMA/TMA/TAC timer (FF04-FF07) with falling-edge TIMA increment and delayed TMA reload.
// Optional: define GBC_TIMER_STOP_CLEAR_EN to let I_STOP_CLEAR clear the divider like a DIV write.
module gbc_timer
    import gbc_timer_pkg::*;
#(
    parameter int unsigned P_RELOAD_DELAY = 4
) (
    input  logic        I_CLK,
    input  logic        I_SYNC_RESET,
    gbc_timer_if.slave  bus,
    inout  wire  [7:0]  IO_IOREG_DATA,
    input  logic        I_FREEZE,
    input  logic        I_STOP_CLEAR,
    output logic        O_TIMER_INT
);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tick_q, tick_d;

    logic       wr_en, rd_en, rd_hit;
    logic [7:0] wdata, rd_data;
    logic       div_wr, tima_wr, tma_wr, tac_wr;
    logic       div_clr;
    logic       tick, inc, ovf, reload;

    assign wr_en   = !bus.I_IOREG_WE_L;
    assign wdata   = IO_IOREG_DATA;
    assign div_wr  = wr_en && (bus.I_IOREG_ADDR == ADDR_DIV);
    assign tima_wr = wr_en && (bus.I_IOREG_ADDR == ADDR_TIMA);
    assign tma_wr  = wr_en && (bus.I_IOREG_ADDR == ADDR_TMA);
    assign tac_wr  = wr_en && (bus.I_IOREG_ADDR == ADDR_TAC);

`ifdef GBC_TIMER_STOP_CLEAR_EN
    assign div_clr = div_wr || I_STOP_CLEAR;
`else
    logic unused_stop_clear;
    assign unused_stop_clear = I_STOP_CLEAR;
    assign div_clr           = div_wr;
`endif

    // Edge detect on the gated tap; clearing the divider or rewriting TAC can fake a falling edge.
    assign tick = cnt_q[tap_bit(tac_q[1:0])] && tac_q[2];
    assign inc  = !I_FREEZE && tick_q && !tick;
    assign ovf  = inc && (tima_q == 8'hFF) && !tima_wr;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = tick_q;
        tma_d  = tma_q;
        tac_d  = tac_q;
        tima_d = tima_q;

        if (div_clr) begin
            cnt_d = 16'd0;
        end else if (!I_FREEZE) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (!I_FREEZE) begin
            tick_d = tick;
        end

        if (tma_wr) begin
            tma_d = wdata;
        end
        if (tac_wr) begin
            tac_d = wdata[2:0];
        end

        // Reload beats a same-cycle TIMA write; a same-cycle TMA write lands in both registers.
        if (reload) begin
            tima_d = tma_wr ? wdata : tma_q;
        end else if (tima_wr) begin
            tima_d = wdata;
        end else if (inc) begin
            tima_d = tima_q + 8'd1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RESET) begin
            cnt_q  <= 16'd0;
            tima_q <= 8'd0;
            tma_q  <= 8'd0;
            tac_q  <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            tick_q <= tick_d;
        end
    end

    gbc_timer_reload_fsm #(
        .P_RELOAD_DELAY (P_RELOAD_DELAY)
    ) u_reload_fsm (
        .clk_i        (I_CLK),
        .sync_reset_i (I_SYNC_RESET),
        .freeze_i     (I_FREEZE),
        .ovf_i        (ovf),
        .tima_wr_i    (tima_wr),
        .reload_o     (reload)
    );

    assign O_TIMER_INT = reload;

    always_comb begin
        rd_data = 8'h00;
        rd_hit  = 1'b1;
        case (bus.I_IOREG_ADDR)
            ADDR_DIV:  rd_data = cnt_q[15:8];
            ADDR_TIMA: rd_data = tima_q;
            ADDR_TMA:  rd_data = tma_q;
            ADDR_TAC:  rd_data = {TAC_PAD_BITS, tac_q};
            default:   rd_hit  = 1'b0;
        endcase
    end

    assign rd_en         = !bus.I_IOREG_RE_L && rd_hit;
    assign IO_IOREG_DATA = rd_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_gbc_timer.sv
// Directed bench for gbc_timer: reset, DIV/TIMA counting, overflow reload, cancel, glitches, freeze.
module tb_gbc_timer;

    logic clk = 1'b0;
    logic sync_reset;
    logic freeze;
    logic stop_clear;
    logic timer_int;

    logic       tb_drive;
    logic [7:0] tb_wdata;
    wire  [7:0] data_bus;

    int checks = 0;
    int errors = 0;
    int int_cnt = 0;
    int frz_int_cnt = 0;
    int int_base;

    assign data_bus = tb_drive ? tb_wdata : 8'hzz;

    gbc_timer_if bus_if ();

    gbc_timer #(
        .P_RELOAD_DELAY (4)
    ) dut (
        .I_CLK         (clk),
        .I_SYNC_RESET  (sync_reset),
        .bus           (bus_if.slave),
        .IO_IOREG_DATA (data_bus),
        .I_FREEZE      (freeze),
        .I_STOP_CLEAR  (stop_clear),
        .O_TIMER_INT   (timer_int)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timer_int === 1'b1) begin
            int_cnt++;
            if (freeze === 1'b1) frz_int_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_if.I_IOREG_ADDR = a;
        bus_if.I_IOREG_WE_L = 1'b0;
        tb_wdata = d;
        tb_drive = 1'b1;
        step(1);
        bus_if.I_IOREG_WE_L = 1'b1;
        tb_drive = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_if.I_IOREG_ADDR = a;
        bus_if.I_IOREG_RE_L = 1'b0;
        #1;
        d = data_bus;
        bus_if.I_IOREG_RE_L = 1'b1;
        check(tag, {8'h00, d}, {8'h00, exp});
    endtask

    initial begin
        sync_reset = 1'b1;
        freeze = 1'b0;
        stop_clear = 1'b0;
        tb_drive = 1'b0;
        tb_wdata = 8'h00;
        bus_if.I_IOREG_ADDR = 16'h0000;
        bus_if.I_IOREG_WE_L = 1'b1;
        bus_if.I_IOREG_RE_L = 1'b1;
        step(3);
        sync_reset = 1'b0;

        // Reset state, then 256 free-running cycles
        rd_check("rst_div", 16'hFF04, 8'h00);
        rd_check("rst_tima", 16'hFF05, 8'h00);
        rd_check("rst_tma", 16'hFF06, 8'h00);
        rd_check("rst_tac", 16'hFF07, 8'hF8);
        check("rst_int", {15'd0, timer_int}, 16'd0);
        step(256);
        rd_check("div_256", 16'hFF04, 8'h01);
        rd_check("tima_256", 16'hFF05, 8'h00);
        check("no_int_256", 16'(int_cnt), 16'd0);

        // Overflow and reload: divider aligned to 0, tap bit 3
        wr(16'hFF06, 8'hF0);
        wr(16'hFF04, 8'h00);                 // cnt=0
        wr(16'hFF05, 8'hFE);                 // cnt=1
        wr(16'hFF07, 8'h05);                 // cnt=2
        rd_check("tac_05", 16'hFF07, 8'hFD);
        step(14);                            // cnt=16
        rd_check("tima_fe", 16'hFF05, 8'hFE);
        step(1);                             // cnt=17
        rd_check("tima_ff", 16'hFF05, 8'hFF);
        int_base = int_cnt;
        step(16);                            // cnt=33, overflow
        rd_check("ovf_0", 16'hFF05, 8'h00);
        check("ovf_no_int", {15'd0, timer_int}, 16'd0);
        step(3);                             // cnt=36, reload cycle
        rd_check("ovf_3", 16'hFF05, 8'h00);
        check("reload_int", {15'd0, timer_int}, 16'd1);
        step(1);                             // cnt=37
        rd_check("reload_tma", 16'hFF05, 8'hF0);
        check("int_after", {15'd0, timer_int}, 16'd0);
        check("one_pulse", 16'(int_cnt - int_base), 16'd1);

        // Cancel: TIMA write two cycles after overflow
        wr(16'hFF05, 8'hFF);                 // cnt=38
        step(11);                            // cnt=49, overflow
        rd_check("cancel_ovf", 16'hFF05, 8'h00);
        int_base = int_cnt;
        step(1);                             // cnt=50
        wr(16'hFF05, 8'h33);                 // cnt=51
        rd_check("cancel_wr", 16'hFF05, 8'h33);
        step(5);                             // cnt=56
        rd_check("cancel_hold", 16'hFF05, 8'h33);
        check("cancel_no_int", 16'(int_cnt - int_base), 16'd0);

        // DIV write with tap bit high -> glitch increment
        step(2);                             // cnt=58
        wr(16'hFF04, 8'h5C);                 // cnt=0
        rd_check("divclr_div", 16'hFF04, 8'h00);
        rd_check("divclr_pre", 16'hFF05, 8'h33);
        step(1);
        rd_check("divclr_glitch", 16'hFF05, 8'h34);

        // TAC write that drops the selected tap -> glitch increment
        step(8);                             // cnt=9
        wr(16'hFF07, 8'h04);                 // cnt=10
        rd_check("tacwr_pre", 16'hFF05, 8'h34);
        rd_check("tac_04", 16'hFF07, 8'hFC);
        step(1);                             // cnt=11
        rd_check("tacwr_glitch", 16'hFF05, 8'h35);

        // Freeze in the middle of an overflow wait
        wr(16'hFF05, 8'hFF);                 // cnt=12
        wr(16'hFF07, 8'h05);                 // cnt=13
        step(4);                             // cnt=17, overflow
        rd_check("frz_ovf", 16'hFF05, 8'h00);
        int_base = int_cnt;
        step(1);                             // cnt=18
        freeze = 1'b1;
        step(150);
        wr(16'hFF06, 8'h5A);
        step(149);
        rd_check("frz_tima", 16'hFF05, 8'h00);
        rd_check("frz_div", 16'hFF04, 8'h00);
        rd_check("frz_tma_wr", 16'hFF06, 8'h5A);
        check("frz_no_int", 16'(int_cnt - int_base), 16'd0);
        freeze = 1'b0;
        step(2);                             // cnt=20, reload cycle
        check("unfrz_int", {15'd0, timer_int}, 16'd1);
        rd_check("unfrz_pre", 16'hFF05, 8'h00);
        step(1);                             // cnt=21
        rd_check("unfrz_reload", 16'hFF05, 8'h5A);
        check("unfrz_pulse", 16'(int_cnt - int_base), 16'd1);
        check("frz_int_any", 16'(frz_int_cnt), 16'd0);
        step(234);                           // cnt=255
        rd_check("resume_255", 16'hFF04, 8'h00);
        step(1);                             // cnt=256
        rd_check("resume_256", 16'hFF04, 8'h01);

        // Reset in the middle of an overflow wait
        wr(16'hFF05, 8'hFF);                 // cnt=257
        step(16);                            // cnt=273, overflow
        rd_check("rstovf_ovf", 16'hFF05, 8'h00);
        int_base = int_cnt;
        sync_reset = 1'b1;
        step(1);
        sync_reset = 1'b0;
        rd_check("rstovf_tima", 16'hFF05, 8'h00);
        rd_check("rstovf_tma", 16'hFF06, 8'h00);
        rd_check("rstovf_tac", 16'hFF07, 8'hF8);
        rd_check("rstovf_div", 16'hFF04, 8'h00);
        step(10);                            // cnt=10
        check("rstovf_no_int", 16'(int_cnt - int_base), 16'd0);
        rd_check("rstovf_tima2", 16'hFF05, 8'h00);

        // STOP clear at DIV=0x7A
        step(16'h7A00 - 10);                 // cnt=0x7A00
        rd_check("stop_pre", 16'hFF04, 8'h7A);
        stop_clear = 1'b1;
        step(1);
        stop_clear = 1'b0;
`ifdef GBC_TIMER_STOP_CLEAR_EN
        rd_check("stop_clr", 16'hFF04, 8'h00);
        step(256);
        rd_check("stop_after", 16'hFF04, 8'h01);
`else
        rd_check("stop_ign", 16'hFF04, 8'h7A);
        step(256);
        rd_check("stop_after", 16'hFF04, 8'h7B);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
